// File: rtl/systolic_array_rxc.sv
// systolic_array_rxc: ROWS x COLS output-stationary int8 systolic matmul tile.
// Operands arrive unskewed (one column of A and one row of B per beat); the
// diagonal skew is applied internally. A valid bit rides along the A path so
// bubbles never accumulate. Results are drained one row per handshake.
module systolic_array_rxc #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  localparam int ROW_W      = (ROWS > 32'sd1) ? $clog2(ROWS) : 32'sd1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_a,
  input  logic [COLS*DATA_WIDTH-1:0]    in_b,
  input  logic                          in_last,
  input  logic                          accum_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*ACCUM_WIDTH-1:0]   out_data,
  output logic [ROW_W-1:0]              out_row,
  output logic                          out_last,
  output logic                          busy
);

  // Cycles between the last accepted beat and the final product landing in PE(ROWS-1,COLS-1)
  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int CNT_W     = $clog2(ROWS + COLS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    next_cnt_s;
  logic [ROW_W-1:0]    row_r;
  logic [ROW_W-1:0]    next_row_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic                busy_r;

  logic                accept_s;
  logic                clear_s;

  // Skewed lane outputs feeding the array edges
  logic signed [DATA_WIDTH-1:0] a_lane_s [ROWS];
  logic                         v_lane_s [ROWS];
  logic signed [DATA_WIDTH-1:0] b_lane_s [COLS];

  // PE operand inputs and inter-PE hop registers
  logic signed [DATA_WIDTH-1:0]  a_in_s  [ROWS][COLS];
  logic                          v_in_s  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_in_s  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  a_hop_r [ROWS][COLS];
  logic                          v_hop_r [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_hop_r [ROWS][COLS];
  logic signed [ACCUM_WIDTH-1:0] acc_r   [ROWS][COLS];

  assign accept_s = in_valid & in_ready_r;
  // The first accepted beat of a tile clears all accumulators unless K-split keep is requested
  assign clear_s  = accept_s & (state_r == ST_IDLE) & ~accum_keep;

  // ---------------------------------------------------------------- A skew
  for (genvar r = 0; r < ROWS; r++) begin : gen_skew_a
    if (r == 0) begin : g_direct
      assign a_lane_s[r] = in_a[r*DATA_WIDTH +: DATA_WIDTH];
      assign v_lane_s[r] = accept_s;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sa_r [r];
      logic                         sv_r [r];
      // Delay A lane r and its valid bit by r cycles
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            sa_r[i] <= {DATA_WIDTH{1'b0}};
            sv_r[i] <= 1'b0;
          end
        end else begin
          sa_r[0] <= in_a[r*DATA_WIDTH +: DATA_WIDTH];
          sv_r[0] <= accept_s;
          for (int i = 1; i < r; i++) begin
            sa_r[i] <= sa_r[i-1];
            sv_r[i] <= sv_r[i-1];
          end
        end
      end
      assign a_lane_s[r] = sa_r[r-1];
      assign v_lane_s[r] = sv_r[r-1];
    end
  end

  // ---------------------------------------------------------------- B skew
  for (genvar c = 0; c < COLS; c++) begin : gen_skew_b
    if (c == 0) begin : g_direct
      assign b_lane_s[c] = in_b[c*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sb_r [c];
      // Delay B lane c by c cycles
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) begin
            sb_r[i] <= {DATA_WIDTH{1'b0}};
          end
        end else begin
          sb_r[0] <= in_b[c*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < c; i++) begin
            sb_r[i] <= sb_r[i-1];
          end
        end
      end
      assign b_lane_s[c] = sb_r[c-1];
    end
  end

  // ---------------------------------------------------------------- PE grid
  for (genvar r = 0; r < ROWS; r++) begin : gen_row
    for (genvar c = 0; c < COLS; c++) begin : gen_col
      logic signed [2*DATA_WIDTH-1:0]  prod_s;
      logic signed [ACCUM_WIDTH-1:0]   prod_ext_s;

      if (c == 0) begin : g_west_edge
        assign a_in_s[r][c] = a_lane_s[r];
        assign v_in_s[r][c] = v_lane_s[r];
      end else begin : g_west_hop
        assign a_in_s[r][c] = a_hop_r[r][c-1];
        assign v_in_s[r][c] = v_hop_r[r][c-1];
      end

      if (r == 0) begin : g_north_edge
        assign b_in_s[r][c] = b_lane_s[c];
      end else begin : g_north_hop
        assign b_in_s[r][c] = b_hop_r[r-1][c];
      end

      assign prod_s     = a_in_s[r][c] * b_in_s[r][c];
      assign prod_ext_s = ACCUM_WIDTH'(prod_s);

      // Forward operands east/south and accumulate valid products (clear-then-add on tile start)
      always_ff @(posedge clk) begin
        if (rst) begin
          a_hop_r[r][c] <= {DATA_WIDTH{1'b0}};
          v_hop_r[r][c] <= 1'b0;
          b_hop_r[r][c] <= {DATA_WIDTH{1'b0}};
          acc_r[r][c]   <= {ACCUM_WIDTH{1'b0}};
        end else begin
          a_hop_r[r][c] <= a_in_s[r][c];
          v_hop_r[r][c] <= v_in_s[r][c];
          b_hop_r[r][c] <= b_in_s[r][c];
          if (clear_s) begin
            acc_r[r][c] <= v_in_s[r][c] ? prod_ext_s : {ACCUM_WIDTH{1'b0}};
          end else if (v_in_s[r][c]) begin
            acc_r[r][c] <= acc_r[r][c] + prod_ext_s;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- control
  // Next-state logic for feed / flush / drain sequencing
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_row_s   = row_r;
    case (state_r)
      ST_IDLE, ST_FEED: begin
        if (accept_s) begin
          if (in_last) begin
            next_row_s = {ROW_W{1'b0}};
            next_cnt_s = {CNT_W{1'b0}};
            if (FLUSH_LEN == 32'sd0) begin
              next_state_s = ST_DRAIN;
            end else begin
              next_state_s = ST_FLUSH;
            end
          end else begin
            next_state_s = ST_FEED;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == CNT_W'(FLUSH_LEN - 32'sd1)) begin
          next_state_s = ST_DRAIN;
          next_row_s   = {ROW_W{1'b0}};
        end else begin
          next_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_r == ROW_W'(ROWS - 32'sd1)) begin
            next_state_s = ST_IDLE;
            next_row_s   = {ROW_W{1'b0}};
          end else begin
            next_row_s   = row_r + ROW_W'(1);
          end
        end else begin
          next_row_s = row_r;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = {CNT_W{1'b0}};
        next_row_s   = {ROW_W{1'b0}};
      end
    endcase
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= next_cnt_s;
      row_r       <= next_row_s;
      in_ready_r  <= (next_state_s == ST_IDLE) || (next_state_s == ST_FEED);
      out_valid_r <= (next_state_s == ST_DRAIN);
      out_last_r  <= (next_state_s == ST_DRAIN) && (next_row_s == ROW_W'(ROWS - 32'sd1));
      busy_r      <= (next_state_s != ST_IDLE);
    end
  end

  // Present the held accumulators of the selected row
  always_comb begin
    out_data = {(COLS*ACCUM_WIDTH){1'b0}};
    for (int c = 0; c < COLS; c++) begin
      out_data[c*ACCUM_WIDTH +: ACCUM_WIDTH] = acc_r[row_r][c];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_row   = row_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_systolic_array_rxc.sv
// Self-checking bench for systolic_array_rxc: directed tiles plus randomized
// tiles, checked against a plain matrix-multiply reference with 16-bit wrap.
module tb_systolic_array_rxc;

  localparam int R    = 4;
  localparam int C    = 3;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KMAX = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [R*DW-1:0] in_a;
  logic [C*DW-1:0] in_b;
  logic            in_last;
  logic            accum_keep;
  logic            out_valid;
  logic            out_ready;
  logic [C*AW-1:0] out_data;
  logic [1:0]      out_row;
  logic            out_last;
  logic            busy;

  systolic_array_rxc #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .accum_keep(accum_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;

  logic signed [DW-1:0] ta  [R][KMAX];
  logic signed [DW-1:0] tb  [KMAX][C];
  logic signed [AW-1:0] mdl [R][C];
  logic signed [AW-1:0] got [R][C];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: C = (keep ? C_prev : 0) + A*B, wrapped to AW bits
  task automatic model_tile(input int k_len, input bit keep);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        int s;
        s = keep ? int'(mdl[r][c]) : 0;
        for (int k = 0; k < k_len; k++) s += int'(ta[r][k]) * int'(tb[k][c]);
        mdl[r][c] = s[AW-1:0];
      end
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mdl[r][c] = '0;
  endtask

  task automatic fill_const(input int k_len, input int av, input int bv);
    for (int k = 0; k < k_len; k++) begin
      for (int r = 0; r < R; r++) ta[r][k] = DW'(av);
      for (int c = 0; c < C; c++) tb[k][c] = DW'(bv);
    end
  endtask

  task automatic feed_beats(input int k_len, input bit keep, input bit bubbles);
    int k = 0;
    int guard = 0;
    bit hole = 1'b0;
    while (k < k_len && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bubbles) check_val("in_ready_feed", in_ready, 1);
      if (bubbles && hole) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int r = 0; r < R; r++) in_a[r*DW +: DW] = ta[r][k];
        for (int c = 0; c < C; c++) in_b[c*DW +: DW] = tb[k][c];
        in_last    = (k == k_len - 1);
        accum_keep = keep;
      end
      if (bubbles) hole = !hole;
      if (in_valid && in_ready) begin
        last_acc_cyc = cyc;
        k++;
      end
    end
    if (k < k_len) check_val("feed_timeout", k, k_len);
  endtask

  task automatic drain_tile(input int stall_row, input int stall_len, input bit rand_ready);
    int row = 0;
    int guard = 0;
    int stalled = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check_val("in_ready_flush", in_ready, 0);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check_val("out_valid_timeout", out_valid, 1);
      return;
    end
    check_val("latency", cyc - last_acc_cyc, R + C - 1);
    guard = 0;
    while (row < R && guard < 100) begin
      guard++;
      check_val("out_valid", out_valid, 1);
      if (row == stall_row && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = (R*DW)'($urandom);
        in_b     = (C*DW)'($urandom);
        check_val("in_ready_stall", in_ready, 0);
        check_val("row_stall", out_row, row);
        for (int c = 0; c < C; c++)
          check_val("data_stall", $signed(out_data[c*AW +: AW]), mdl[row][c]);
      end else begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (out_ready) begin
        check_val("out_row", out_row, row);
        check_val("out_last", out_last, (row == R - 1) ? 1 : 0);
        for (int c = 0; c < C; c++) begin
          got[row][c] = out_data[c*AW +: AW];
          check_val("out_data", got[row][c], mdl[row][c]);
        end
        row++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    if (row < R) check_val("drain_timeout", row, R);
    check_val("in_ready_after", in_ready, 1);
    check_val("busy_after", busy, 0);
    check_val("out_valid_after", out_valid, 0);
  endtask

  task automatic run_tile(input int k_len, input bit keep, input bit bubbles,
                          input int stall_row, input int stall_len, input bit rand_ready);
    model_tile(k_len, keep);
    feed_beats(k_len, keep, bubbles);
    drain_tile(stall_row, stall_len, rand_ready);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    accum_keep = 1'b0; out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_out_row", out_row, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Identity A, B[k][c] = 10k + c: result rows equal B rows
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < R; r++) ta[r][k] = (r == k) ? 8'sd1 : 8'sd0;
      for (int c = 0; c < C; c++) tb[k][c] = DW'(10 * k + c);
    end
    run_tile(4, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int c = 0; c < C; c++) check_val("ident_row2", got[2][c], 20 + c);

    // Same data with bubbles between beats
    run_tile(4, 1'b0, 1'b1, -1, 0, 1'b0);
    for (int c = 0; c < C; c++) check_val("bubble_row2", got[2][c], 20 + c);

    // K-split with all-ones operands
    fill_const(3, 1, 1);
    run_tile(2, 1'b0, 1'b0, -1, 0, 1'b0);
    check_val("ksplit_t1", got[3][2], 2);
    run_tile(3, 1'b1, 1'b0, -1, 0, 1'b0);
    check_val("ksplit_t2", got[1][1], 5);
    run_tile(1, 1'b0, 1'b0, -1, 0, 1'b0);
    check_val("ksplit_t3", got[0][0], 1);

    // Backpressure on row 1 for 5 cycles with random operands
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < R; r++) ta[r][k] = DW'($urandom);
      for (int c = 0; c < C; c++) tb[k][c] = DW'($urandom);
    end
    run_tile(3, 1'b0, 1'b0, 1, 5, 1'b0);

    // Signed wrap
    fill_const(2, -128, -128);
    run_tile(2, 1'b0, 1'b0, -1, 0, 1'b0);
    check_val("wrap_neg", got[2][1], -32768);
    fill_const(1, -128, 127);
    run_tile(1, 1'b0, 1'b0, -1, 0, 1'b0);
    check_val("wrap_mixed", got[3][0], -16256);

    // Reset in the middle of FLUSH
    fill_const(7, 1, 1);
    feed_beats(7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_val("flush_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_out_data", out_data, 0);
    clear_model();
    run_tile(1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_val("midrst_keep", got[3][2], 1);

    // Randomized tiles
    for (int t = 0; t < 12; t++) begin
      int kl;
      kl = $urandom_range(1, KMAX);
      for (int k = 0; k < kl; k++) begin
        for (int r = 0; r < R; r++) ta[r][k] = DW'($urandom);
        for (int c = 0; c < C; c++) tb[k][c] = DW'($urandom);
      end
      run_tile(kl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, R - 1), $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
